deserialize: RTL and testbench

- Inverse of the output serializer: accepts a narrow word stream (one value per word) and assembles N consecutive values into one wide parallel vector.
- Sits on the host-to-model input path. The DE1SoC adapter feeds it 32-bit words; it presents multi-channel vectors to the model input (in_data[N] / in_valid / in_last).
- Uses the same valid/stall handshake as the rest of the adapter layer.

---
 rtl/adapter_pkg.sv | 10 +
 rtl/deserialize.sv | 102 ++++++++++
 tb/tb_deserialize.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/adapter_pkg.sv
// Shared adapter-layer constants and value type used by the host-to-model path.
package adapter_pkg;

    localparam int unsigned VALUE_BITS        = 18;
    localparam int unsigned DEFAULT_WORD_SIZE = 32;
    localparam int unsigned SOFT_RESET_BIT    = DEFAULT_WORD_SIZE - 1;

    typedef logic signed [VALUE_BITS-1:0] value_t;

endpackage

// File: rtl/deserialize.sv
// Assembles N consecutive narrow words into one wide vector with valid/stall handshake.
// Optional control-word soft reset on the top input bit: DESERIALIZE_SOFT_RESET_EN.
module deserialize
    import adapter_pkg::*;
#(
    parameter int unsigned N         = 10,
    parameter int unsigned DATA_BITS = VALUE_BITS,
    parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WORD_SIZE-1:0]        in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        upstream_stall,
    output logic signed [DATA_BITS-1:0] out_data [N],
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        downstream_stall
);

    localparam int unsigned      IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0]            idx_q;
    logic signed [DATA_BITS-1:0] acc_q [N-1];
    logic signed [DATA_BITS-1:0] out_q [N];
    logic signed [DATA_BITS-1:0] vec_d [N];
    logic                        out_valid_q;
    logic                        out_last_q;

    logic signed [DATA_BITS-1:0] word_val;
    logic                        ctrl_word;
    logic                        completing;
    logic                        accept;
    logic                        xfer;
    logic                        unused_bits;

    assign word_val = in_data[DATA_BITS-1:0];

`ifdef DESERIALIZE_SOFT_RESET_EN
    assign ctrl_word   = in_valid && in_data[WORD_SIZE-1];
    assign unused_bits = ^in_data[WORD_SIZE-2:DATA_BITS];
`else
    assign ctrl_word   = 1'b0;
    assign unused_bits = ^in_data[WORD_SIZE-1:DATA_BITS];
`endif

    // Only a word that would overwrite the output register can be stalled.
    assign completing     = in_valid && !ctrl_word && ((idx_q == LAST_IDX) || in_last);
    assign upstream_stall = completing && out_valid_q && downstream_stall;
    assign accept         = in_valid && !upstream_stall;
    assign xfer           = out_valid_q && !downstream_stall;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            vec_d[i] = (IDX_W'(i) == idx_q) ? word_val : '0;
        end
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (IDX_W'(i) < idx_q) begin
                vec_d[i] = acc_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int unsigned i = 0; i < N - 1; i++) acc_q[i] <= '0;
            for (int unsigned i = 0; i < N; i++)     out_q[i] <= '0;
        end else if (ctrl_word) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int unsigned i = 0; i < N - 1; i++) acc_q[i] <= '0;
            for (int unsigned i = 0; i < N; i++)     out_q[i] <= '0;
        end else if (accept && completing) begin
            // A reload here also covers a same-cycle transfer: valid stays high.
            out_q       <= vec_d;
            out_valid_q <= 1'b1;
            out_last_q  <= in_last;
            idx_q       <= '0;
            for (int unsigned i = 0; i < N - 1; i++) acc_q[i] <= '0;
        end else begin
            if (accept) begin
                acc_q[idx_q] <= word_val;
                idx_q        <= idx_q + 1'b1;
            end
            if (xfer) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_deserialize.sv
// Directed-vector bench for deserialize; exercises soft reset when DESERIALIZE_SOFT_RESET_EN is defined.
module tb_deserialize;

    localparam int N  = 10;
    localparam int DB = 18;
    localparam int WS = 32;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [WS-1:0]        in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic                 upstream_stall;
    logic signed [DB-1:0] out_data [N];
    logic                 out_valid;
    logic                 out_last;
    logic                 downstream_stall = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    deserialize #(.N(N), .DATA_BITS(DB), .WORD_SIZE(WS)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .upstream_stall   (upstream_stall),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .downstream_stall (downstream_stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_vec(input string tag, input int exp [N]);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s[%0d]", tag, i), out_data[i], exp[i]);
        end
    endtask

    // Called at a negedge; presents one word across the next posedge.
    task automatic send(input logic [WS-1:0] w, input logic last, input logic exp_stall);
        in_data  = w;
        in_valid = 1'b1;
        in_last  = last;
        #1 check("stall", upstream_stall, exp_stall);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_stall", upstream_stall, 0);
        check_vec("rst_data", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        reset = 1'b1;
        @(negedge clock);

        // Continuous full frame
        for (int k = 1; k <= 9; k++) send(WS'(k), 1'b0, 1'b0);
        check("t1_valid_early", out_valid, 0);
        send(32'd10, 1'b0, 1'b0);
        check("t1_valid", out_valid, 1);
        check("t1_last", out_last, 0);
        check_vec("t1_data", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        idle();
        check("t1_drain", out_valid, 0);

        // Upper bits ignored, sign kept; idle gap holds idx
        send(32'h0003_FFFF, 1'b0, 1'b0);
        send(32'h001F_FFFF, 1'b0, 1'b0);
        for (int k = 3; k <= 5; k++) send(WS'(k), 1'b0, 1'b0);
        repeat (3) idle();
        check("t2_gap_valid", out_valid, 0);
        for (int k = 6; k <= 10; k++) send(WS'(k), 1'b0, 1'b0);
        check("t2_valid", out_valid, 1);
        check_vec("t2_data", '{-1, -1, 3, 4, 5, 6, 7, 8, 9, 10});
        idle();

        // Early last: zero-padded, then restart at index 0
        send(32'd5, 1'b0, 1'b0);
        send(32'd6, 1'b0, 1'b0);
        send(32'd7, 1'b0, 1'b0);
        send(32'd8, 1'b1, 1'b0);
        check("t3_valid", out_valid, 1);
        check("t3_last", out_last, 1);
        check_vec("t3_data", '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0});
        idle();
        check("t3_drain_valid", out_valid, 0);
        check("t3_drain_last", out_last, 0);
        send(32'd9, 1'b1, 1'b0);
        check_vec("t3_next", '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        check("t3_next_last", out_last, 1);
        idle();

        // Backpressure: only the completing word stalls; release reloads without a bubble
        downstream_stall = 1'b1;
        for (int k = 1; k <= 10; k++) send(WS'(k), 1'b0, 1'b0);
        check("t4_held_valid", out_valid, 1);
        for (int k = 11; k <= 19; k++) send(WS'(k), 1'b0, 1'b0);
        in_data  = 32'd20;
        in_valid = 1'b1;
        #1 check("t4_stall20", upstream_stall, 1);
        @(negedge clock);
        check("t4_hold_valid", out_valid, 1);
        check_vec("t4_hold_data", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        #1 check("t4_stall_again", upstream_stall, 1);
        downstream_stall = 1'b0;
        #1 check("t4_release", upstream_stall, 0);
        @(negedge clock);
        in_valid = 1'b0;
        check("t4_nobubble", out_valid, 1);
        check("t4_last", out_last, 0);
        check_vec("t4_data", '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20});
        idle();
        check("t4_drain", out_valid, 0);

        // Asynchronous reset mid-frame with a pending vector
        downstream_stall = 1'b1;
        for (int k = 1; k <= 10; k++) send(WS'(k), 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) send(WS'(k + 40), 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 check("t5_async_valid", out_valid, 0);
        check("t5_async_data0", out_data[0], 0);
        check("t5_async_stall", upstream_stall, 0);
        @(negedge clock);
        reset = 1'b1;
        downstream_stall = 1'b0;
        for (int k = 0; k <= 9; k++) send(WS'(100 + k), 1'b0, 1'b0);
        check("t5_valid", out_valid, 1);
        check("t5_last", out_last, 0);
        check_vec("t5_data", '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109});
        idle();

`ifdef DESERIALIZE_SOFT_RESET_EN
        // Control word drops the pending vector and partial frame
        downstream_stall = 1'b1;
        for (int k = 1; k <= 10; k++) send(WS'(k), 1'b0, 1'b0);
        send(32'd1, 1'b0, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        send(32'd3, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b0, 1'b0);
        check("t6_valid", out_valid, 0);
        check("t6_last", out_last, 0);
        downstream_stall = 1'b0;
        for (int k = 0; k <= 8; k++) send(WS'(200 + k), 1'b0, 1'b0);
        check("t6_not_early", out_valid, 0);
        send(32'd209, 1'b0, 1'b0);
        check("t6_valid_after", out_valid, 1);
        check_vec("t6_data", '{200, 201, 202, 203, 204, 205, 206, 207, 208, 209});
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
